// File: rtl/msg_packer_if.sv
// Handshake bundle for msg_packer: whole messages in, 64-bit framed beats out.
// A transfer happens on the rising clk edge where valid & ready are both high; valid never waits on ready.
interface msg_packer_if #(
    parameter int OP_DATA_WIDTH = 64,
    parameter int IP_DATA_WIDTH = 256,
    parameter int IP_BM_WIDTH   = 32
);
    localparam int EW = $clog2(OP_DATA_WIDTH / 8);

    logic                     in_valid;
    logic                     in_ready;
    logic [IP_DATA_WIDTH-1:0] in_data;
    logic [IP_BM_WIDTH-1:0]   in_bytemask;
    logic [15:0]              in_msg_count;
    logic                     out_valid;
    logic                     out_ready;
    logic [OP_DATA_WIDTH-1:0] out_data;
    logic                     out_startofpayload;
    logic                     out_endofpayload;
    logic [EW-1:0]            out_empty;
    logic                     out_error;

    modport master (
        output in_valid, in_data, in_bytemask, in_msg_count, out_ready,
        input  in_ready, out_valid, out_data, out_startofpayload, out_endofpayload, out_empty, out_error
    );

    modport slave (
        input  in_valid, in_data, in_bytemask, in_msg_count, out_ready,
        output in_ready, out_valid, out_data, out_startofpayload, out_endofpayload, out_empty, out_error
    );
endinterface

// File: rtl/msg_packer.sv
// Serializes whole messages into a framed 64-bit beat stream: message count, then length + bytes per message.
// Optional PACKER_STATS_EN adds stat_payloads / stat_msgs counters.
module msg_packer #(
    parameter int OP_DATA_WIDTH = 64,
    parameter int IP_DATA_WIDTH = 256,
    parameter int IP_BM_WIDTH   = 32,
    parameter int BUF_BYTES     = 48
) (
    input  logic        clk,
    input  logic        reset,
    msg_packer_if.slave bus,
`ifdef PACKER_STATS_EN
    output logic [31:0] stat_payloads,
    output logic [31:0] stat_msgs,
`endif
    output logic [1:0]  dbg_state
);
    localparam int OB = OP_DATA_WIDTH / 8;
    localparam int BW = BUF_BYTES * 8;
    localparam int PW = IP_DATA_WIDTH + 32;
    localparam int FW = $clog2(BUF_BYTES + 1);
    localparam int LW = $clog2(IP_BM_WIDTH + 1);
    localparam int EW = $clog2(OB);
    localparam logic [FW-1:0] BEAT_BYTES = FW'(OB);
    localparam logic [FW-1:0] READY_MAX  = FW'(BUF_BYTES - 4 - IP_BM_WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MSGS  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]               state;
    logic [BW-1:0]            stage;
    logic [FW-1:0]            fill;
    logic [15:0]              rem;
    logic                     sop_pending;
    logic                     err_flag;

    logic [LW-1:0]            len;
    logic [IP_BM_WIDTH-1:0]   lead_mask;
    logic                     seen_zero;
    logic [IP_DATA_WIDTH-1:0] data_keep;
    logic                     count_zero;
    logic                     malformed;
    logic [15:0]              eff_count;
    logic [PW-1:0]            push_vec;
    logic [FW-1:0]            push_cnt;
    logic [FW-1:0]            pop_cnt;
    logic [FW-1:0]            base;
    logic                     accept;
    logic                     fire;
    logic                     eop;
    logic                     beat_valid;
    logic [BW-1:0]            stage_next;

    // Only the leading run of ones counts as payload; anything after the first zero is dropped.
    always_comb begin
        len       = '0;
        lead_mask = '0;
        seen_zero = 1'b0;
        for (int i = IP_BM_WIDTH - 1; i >= 0; i--) begin
            if (!bus.in_bytemask[i]) begin
                seen_zero = 1'b1;
            end else if (!seen_zero) begin
                len          = len + LW'(1);
                lead_mask[i] = 1'b1;
            end
        end
        data_keep = '0;
        for (int b = 0; b < IP_BM_WIDTH; b++) begin
            data_keep[IP_DATA_WIDTH-1-8*b -: 8] = lead_mask[IP_BM_WIDTH-1-b] ?
                                                  bus.in_data[IP_DATA_WIDTH-1-8*b -: 8] : 8'h00;
        end
    end

    assign count_zero = (bus.in_msg_count == 16'd0);
    assign eff_count  = count_zero ? 16'd1 : bus.in_msg_count;
    assign malformed  = (bus.in_bytemask != lead_mask) || (len == '0);

    always_comb begin
        if (state == S_IDLE) begin
            push_vec = {eff_count, 16'(len), data_keep};
            push_cnt = FW'(len) + FW'(4);
        end else begin
            push_vec = {16'(len), data_keep, 16'h0000};
            push_cnt = FW'(len) + FW'(2);
        end
    end

    assign bus.in_ready = !reset && (state != S_DRAIN) && (fill <= READY_MAX);
    assign accept       = bus.in_valid && bus.in_ready;
    assign beat_valid   = (fill >= BEAT_BYTES) || (state == S_DRAIN && fill != '0);
    assign eop          = (state == S_DRAIN) && (fill <= BEAT_BYTES);
    assign fire         = beat_valid && bus.out_ready;
    assign pop_cnt      = !fire ? '0 : ((fill >= BEAT_BYTES) ? BEAT_BYTES : fill);
    assign base         = fill - pop_cnt;

    // Bytes beyond fill are always zero, so a shift-out plus OR-in keeps the buffer packed.
    assign stage_next = (stage << {pop_cnt, 3'b000}) |
                        (accept ? ({push_vec, {(BW-PW){1'b0}}} >> {base, 3'b000}) : '0);

    assign bus.out_valid          = beat_valid;
    assign bus.out_data           = stage[BW-1 -: OP_DATA_WIDTH];
    assign bus.out_startofpayload = beat_valid && sop_pending;
    assign bus.out_endofpayload   = beat_valid && eop;
    assign bus.out_empty          = (beat_valid && eop) ? EW'(BEAT_BYTES - fill) : '0;
    assign bus.out_error          = beat_valid && eop && err_flag;
    assign dbg_state              = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            stage       <= '0;
            fill        <= '0;
            rem         <= '0;
            sop_pending <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            stage <= stage_next;
            fill  <= fill - pop_cnt + (accept ? push_cnt : '0);
            if (fire) begin
                sop_pending <= 1'b0;
                if (eop) begin
                    state    <= S_IDLE;
                    err_flag <= 1'b0;
                end
            end
            if (accept) begin
                if (malformed || (state == S_IDLE && count_zero)) err_flag <= 1'b1;
                case (state)
                    S_IDLE: begin
                        sop_pending <= 1'b1;
                        rem         <= eff_count - 16'd1;
                        state       <= (eff_count == 16'd1) ? S_DRAIN : S_MSGS;
                    end
                    S_MSGS: begin
                        rem <= rem - 16'd1;
                        if (rem == 16'd1) state <= S_DRAIN;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_payloads <= '0;
            stat_msgs     <= '0;
        end else begin
            if (fire && eop) stat_payloads <= stat_payloads + 32'd1;
            if (accept) stat_msgs <= stat_msgs + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_msg_packer.sv
// Self-checking bench for msg_packer: directed payloads plus random ones against a byte-stream model.
module tb_msg_packer;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
`ifdef PACKER_STATS_EN
    logic [31:0] stat_payloads;
    logic [31:0] stat_msgs;
`endif

    msg_packer_if bus ();

    msg_packer dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
`ifdef PACKER_STATS_EN
        .stat_payloads(stat_payloads),
        .stat_msgs(stat_msgs),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  m_mask[$];
    logic [255:0] m_data[$];
    logic [7:0]   exp_q[$];
    int           push_sz[$];
    logic         exp_err;
    logic [63:0]  first_beat;
    logic [63:0]  second_beat;
    logic [2:0]   last_empty;
    logic         first_err;
    logic         last_err;
    int           n_beats;
    int           msgs_since_reset = 0;
    int           payloads_since_reset = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lead_ones(input logic [31:0] m);
        int n;
        n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (!m[i]) return n;
            n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] ones_mask(input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[31-i] = 1'b1;
        return r;
    endfunction

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    task automatic add_msg(input logic [31:0] mask, input logic [255:0] data);
        m_mask.push_back(mask);
        m_data.push_back(data);
    endtask

    // Wire image of a whole payload: count header, then length + kept bytes per message.
    task automatic build_expected(input logic [15:0] cnt);
        logic [15:0] c;
        int l;
        exp_q.delete();
        push_sz.delete();
        exp_err = (cnt == 16'd0);
        c = exp_err ? 16'd1 : cnt;
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
        foreach (m_mask[i]) begin
            l = lead_ones(m_mask[i]);
            if (m_mask[i] == 32'h0 || m_mask[i] != ones_mask(l)) exp_err = 1'b1;
            exp_q.push_back(8'(l >> 8));
            exp_q.push_back(8'(l));
            for (int k = 0; k < l; k++) exp_q.push_back(m_data[i][255-8*k -: 8]);
            push_sz.push_back(l + 2 + ((i == 0) ? 2 : 0));
        end
    endtask

    // mode 0: ready always, 1: random ready, 2: ready low for 3 cycles from stall_at.
    task automatic run_payload(input logic [15:0] cnt, input int mode, input int stall_at,
                               input int gap_pct, input int abort_after);
        int n, mi, fill, popped, cyc, pop;
        bit done, present, acc, fire, all_acc, exp_ir, exp_ov, exp_eop;
        logic [63:0] exp_beat;
        logic [2:0]  exp_empty;
        build_expected(cnt);
        n = m_mask.size();
        mi = 0; fill = 0; popped = 0; cyc = 0; done = 1'b0; n_beats = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            present = (mi < n) && ($urandom_range(0, 99) >= gap_pct);
            bus.in_valid = present;
            if (present) begin
                bus.in_msg_count = cnt;
                bus.in_bytemask  = m_mask[mi];
                bus.in_data      = m_data[mi];
            end else begin
                bus.in_msg_count = 16'($urandom);
                bus.in_bytemask  = $urandom;
                bus.in_data      = rand_data();
            end
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 99) < 70);
                default: bus.out_ready = !(cyc >= stall_at && cyc < stall_at + 3);
            endcase
            #1;
            all_acc   = (mi == n);
            exp_ir    = !all_acc && fill <= 12;
            exp_ov    = (fill >= 8) || (all_acc && fill > 0);
            exp_eop   = exp_ov && all_acc && fill <= 8;
            exp_empty = exp_eop ? 3'((8 - fill) % 8) : 3'd0;
            check("in_ready", 64'(bus.in_ready), 64'(exp_ir));
            check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            if (exp_ov) begin
                exp_beat = '0;
                for (int k = 0; k < 8; k++)
                    if (k < fill) exp_beat[63-8*k -: 8] = exp_q[popped + k];
                check("out_data", bus.out_data, exp_beat);
                check("out_sop", 64'(bus.out_startofpayload), 64'(popped == 0));
                check("out_eop", 64'(bus.out_endofpayload), 64'(exp_eop));
                check("out_empty", 64'(bus.out_empty), 64'(exp_empty));
                check("out_error", 64'(bus.out_error), 64'(exp_eop && exp_err));
                if (bus.out_valid && bus.out_ready) begin
                    if (n_beats == 0) begin
                        first_beat = bus.out_data;
                        first_err  = bus.out_error;
                    end
                    if (n_beats == 1) second_beat = bus.out_data;
                    if (bus.out_endofpayload) begin
                        last_empty = bus.out_empty;
                        last_err   = bus.out_error;
                    end
                    n_beats++;
                end
            end
            acc  = present && exp_ir;
            fire = exp_ov && bus.out_ready;
            @(posedge clk);
            cyc++;
            if (fire) begin
                pop = (fill >= 8) ? 8 : fill;
                popped += pop;
                fill -= pop;
                if (exp_eop) begin
                    done = 1'b1;
                    payloads_since_reset++;
                end
            end
            if (acc) begin
                fill += push_sz[mi];
                mi++;
                msgs_since_reset++;
                if (mi == abort_after) break;
            end
        end
        if (abort_after < 0) check("payload_done", 64'(done), 64'd1);
        m_mask.delete();
        m_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_data"}, bus.out_data, 64'd0);
        check({tag, "_sop"}, 64'(bus.out_startofpayload), 64'd0);
        check({tag, "_eop"}, 64'(bus.out_endofpayload), 64'd0);
        check({tag, "_empty"}, 64'(bus.out_empty), 64'd0);
        check({tag, "_error"}, 64'(bus.out_error), 64'd0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.in_bytemask  = '0;
        bus.in_msg_count = '0;
        bus.out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_reset_outputs("rst");
        reset = 1'b0;
        #1;
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_state", 64'(dbg_state), 64'd0);

        // Single short message
        add_msg(32'hF000_0000, {32{8'hAA}});
        run_payload(16'd1, 0, 0, 0, -1);
        check("t1_beat", first_beat, 64'h0001_0004_AAAA_AAAA);
        check("t1_beats", 64'(n_beats), 64'd1);
        check("t1_empty", 64'(last_empty), 64'd0);

        // Three messages, then the same with a mid-payload stall
        for (int rep = 0; rep < 2; rep++) begin
            add_msg(32'hFF80_0000, {32{8'h62}});
            add_msg(32'hFFE0_0000, {32{8'h43}});
            add_msg(32'hFFFC_0000, {32{8'h72}});
            run_payload(16'd3, (rep == 0) ? 0 : 2, 2, 0, -1);
            check("t2_beat0", first_beat, 64'h0003_0009_6262_6262);
            check("t2_beat1", second_beat, 64'h6262_6262_6200_0b43);
            check("t2_beats", 64'(n_beats), 64'd6);
            check("t2_empty", 64'(last_empty), 64'd6);
        end

        // Malformed masks: zero mask and a mask with a hole
        add_msg(32'h0000_0000, {32{8'h3C}});
        add_msg(32'hF0F0_0000, {32{8'h3C}});
        run_payload(16'd2, 0, 0, 0, -1);
        check("t4_beat0", first_beat, 64'h0002_0000_0004_3C3C);
        check("t4_first_err", 64'(first_err), 64'd0);
        check("t4_last_err", 64'(last_err), 64'd1);
        check("t4_empty", 64'(last_empty), 64'd6);

        // Reset in the middle of a payload, then a fresh one
        for (int i = 0; i < 3; i++) add_msg(ones_mask($urandom_range(1, 32)), rand_data());
        run_payload(16'd3, 1, 0, 0, 2);
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("t5_rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("t5");
        check("t5_in_ready", 64'(bus.in_ready), 64'd1);
        check("t5_state", 64'(dbg_state), 64'd0);
        msgs_since_reset = 0;
        payloads_since_reset = 0;
        add_msg(32'hF000_0000, {32{8'h5A}});
        run_payload(16'd1, 0, 0, 0, -1);
        check("t5_beat", first_beat, 64'h0001_0004_5A5A_5A5A);
        check("t5_beats", 64'(n_beats), 64'd1);

        // Four full-width messages
        for (int i = 0; i < 4; i++) add_msg(32'hFFFF_FFFF, rand_data());
        run_payload(16'd4, 0, 0, 0, -1);
        check("t6_beats", 64'(n_beats), 64'd18);
        check("t6_empty", 64'(last_empty), 64'd6);

        // Random payloads, including count zero and malformed masks
        for (int p = 0; p < 25; p++) begin
            int cnt;
            int nm;
            cnt = int'($urandom_range(0, 5));
            nm = (cnt == 0) ? 1 : cnt;
            for (int i = 0; i < nm; i++) begin
                logic [31:0] mk;
                if ($urandom_range(0, 7) == 0) mk = $urandom;
                else mk = ones_mask(int'($urandom_range(0, 32)));
                add_msg(mk, rand_data());
            end
            run_payload(16'(cnt), int'($urandom_range(0, 1)), 0, int'($urandom_range(0, 30)), -1);
        end

`ifdef PACKER_STATS_EN
        check("stat_msgs", 64'(stat_msgs), 64'(msgs_since_reset));
        check("stat_payloads", 64'(stat_payloads), 64'(payloads_since_reset));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
